audio_rom_player_ctrl: RTL

AUDIO_ROM_PLAYER_CTRL -- requirements
Module: audio_rom_player_ctrl

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_rom_player_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio ROM player
package audio_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 24;
  localparam int CLIP_LAST  = 48000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/audio_rom_player_ctrl.sv
// rtl/audio_rom_player_ctrl.sv - walks a ROM clip and hands samples to a codec FIFO
module audio_rom_player_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;

  // Both channels carry the same mono sample.
  assign writedata_right = writedata_left;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      rom_addr       <= '0;
      write          <= 1'b0;
      writedata_left <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      start_q        <= '0;
      end_q          <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        write <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (play && (start_addr <= end_addr)) begin
              start_q  <= start_addr;
              end_q    <= end_addr;
              rom_addr <= start_addr;
              busy     <= 1'b1;
              state    <= ST_PRIME;
            end
          end
          ST_PRIME: begin
            writedata_left <= rom_q;
            write          <= 1'b1;
            state          <= ST_VALID;
          end
          ST_VALID: begin
            if (write_ready) begin
              write <= 1'b0;
              // Increment only below the latched end so the address never wraps.
              if (rom_addr != end_q) begin
                rom_addr <= rom_addr + 1'b1;
                state    <= ST_PRIME;
              end else if (loop) begin
                rom_addr <= start_q;
                state    <= ST_PRIME;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            write <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
